pipe_latch: RTL

//  Parametrised, enable-gated pipeline register bank; generalises the fixed 6-bit
//  AND-gated latch stage to WIDTH bits and DEPTH registered stages.

---
 rtl/pipe_latch.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipe_latch.sv
// -----------------------------------------------------------------------------
// pipe_latch
//   Enable-gated pipeline register bank: WIDTH data bits carried through DEPTH
//   registered stages, each with its own valid bit. The bank can hold (stall),
//   advance, or squash its contents (flush). It also reports whether any stage
//   is occupied and how many stages are occupied.
//
//   Parameters
//     WIDTH    data bits per stage (>=1)
//     DEPTH    number of register stages (>=1); latency in advancing cycles
//     RST_VAL  reset value of every data stage register
//
//   Ports
//     clk_i    in   1               rising-edge clock
//     rst_i    in   1               synchronous active-high reset (highest priority)
//     data_i   in   WIDTH           data into stage 0
//     valid_i  in   1               data_i qualifier
//     en_i     in   1               advance this cycle (0 = hold every stage)
//     flush_i  in   1               clear every valid bit at this edge
//     data_o   out  WIDTH           last stage data
//     valid_o  out  1               last stage valid bit
//     busy_o   out  1               any stage valid
//     count_o  out  $clog2(DEPTH+1) number of valid stages
//
//   Build option
//     PIPE_LATCH_GATE_EN  when defined, data_o is forced to zero whenever
//                         valid_o is low (legacy AND-gated output). When not
//                         defined, data_o shows the raw last-stage register,
//                         which is stale while valid_o is low.
// -----------------------------------------------------------------------------
module pipe_latch #(
    parameter int               WIDTH   = 6,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       valid_i,
    input  logic                       en_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       valid_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;

    // Value each stage would take on an advance: stage 0 takes the input
    // port, every later stage takes its upstream neighbour.
    logic [WIDTH-1:0] shift_data [DEPTH];
    logic [DEPTH-1:0] shift_vld;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_src
            if (gi == 0) begin : g_head
                assign shift_data[gi] = data_i;
                assign shift_vld[gi]  = valid_i;
            end else begin : g_body
                assign shift_data[gi] = data_q[gi-1];
                assign shift_vld[gi]  = vld_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            data_d[k] = data_q[k];
        end
        vld_d = vld_q;

        // Data and valid move together; bubbles still carry their stale data.
        if (en_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_d[k] = shift_data[k];
            end
            vld_d = shift_vld;
        end

        // Flush only squashes valid bits; data keeps following en_i since its
        // content is don't-care while invalid. This also discards valid_i.
        if (flush_i) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= RST_VAL;
            end
            vld_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= data_d[k];
            end
            vld_q <= vld_d;
        end
    end

    // Occupancy: popcount of the valid bits, purely from registers.
    logic [CW-1:0] vld_count;

    always_comb begin
        vld_count = '0;
        for (int k = 0; k < DEPTH; k++) begin
            vld_count = vld_count + CW'(vld_q[k]);
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign busy_o  = |vld_q;
    assign count_o = vld_count;

`ifdef PIPE_LATCH_GATE_EN
    assign data_o = data_q[DEPTH-1] & {WIDTH{vld_q[DEPTH-1]}};
`else
    assign data_o = data_q[DEPTH-1];
`endif

endmodule
